// File: rtl/mem_report_scheduler_pkg.sv
// Shared definitions for the memory report scheduler.
//   - MRS_NBYTES(w)       : bytes needed to carry a w-bit field (ceil(w/8))
//   - MRS_ADDR_FIELD/DATA : slices of the {addr,data} word from mem_manager
//   - state_t             : message/response sequencing FSM encoding
//   - header bit positions and hdr_byte() header builder
//   - RR_MEM/RR_RESP      : round-robin pointer encodings
`define MRS_NBYTES(w) (((w) + 7) / 8)
`define MRS_ADDR_FIELD(num, aw, dw) num[(aw) + (dw) - 1 -: (aw)]
`define MRS_DATA_FIELD(num, dw) num[(dw) - 1 : 0]

package mem_report_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_HDR  = 3'd2,
        S_ADDR = 3'd3,
        S_DATA = 3'd4,
        S_RESP = 3'd5
    } state_t;

    localparam int HDR_OVR_BIT  = 7;
    localparam int HDR_REPL_BIT = 1;
    localparam int HDR_NEW_BIT  = 0;

    // Pointer value = requester preferred at the next contested grant.
    localparam logic RR_MEM  = 1'b0;
    localparam logic RR_RESP = 1'b1;

    function automatic logic [7:0] hdr_byte(input logic ovr, input logic repl);
        logic [7:0] h;
        h               = '0;
        h[HDR_OVR_BIT]  = ovr;
        h[HDR_REPL_BIT] = repl;
        h[HDR_NEW_BIT]  = ~repl;
        return h;
    endfunction

endpackage

// File: rtl/mem_report_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter (module rr_arbiter2).
//   clk, reset     : clock, synchronous active-high reset
//   arb_en         : grants are only issued while high
//   req_mem/resp   : requests
//   gnt_mem/resp   : one-hot combinational grant
// The pointer flips to the other requester on every grant, so under
// contention the requester not served last wins.
module rr_arbiter2
    import mem_report_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic req_mem,
    input  logic req_resp,
    output logic gnt_mem,
    output logic gnt_resp
);

    logic prio_q, prio_d;

    always_comb begin
        gnt_mem  = 1'b0;
        gnt_resp = 1'b0;
        prio_d   = prio_q;
        if (arb_en) begin
            if (req_mem && (!req_resp || prio_q == RR_MEM)) gnt_mem = 1'b1;
            else if (req_resp)                              gnt_resp = 1'b1;
        end
        if (gnt_mem)  prio_d = RR_RESP;
        if (gnt_resp) prio_d = RR_MEM;
    end

    always_ff @(posedge clk) begin
        if (reset) prio_q <= RR_MEM;
        else       prio_q <= prio_d;
    end

endmodule

// File: rtl/mem_report_scheduler.sv
// Serialises mem_manager messages and host response bytes onto one UART TX
// byte stream, arbitrating round-robin at message granularity.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   mem_num/replaced/valid  : {addr,data} message from mem_manager
//   mem_overrun             : sticky overrun flag; rising edge -> header bit 7
//   mem_ack                 : one-cycle capture pulse
//   resp_byte/valid/ready   : single-byte host responses
//   tx_byte/valid/ready     : registered byte stream to UART TX
//   busy                    : holding register occupied (includes in-flight msg)
//   filter_replaced         : only with MEM_REPORT_REPLACED_FILTER_EN; drops
//                             replaced=1 messages after acking them
// Message on the wire: header, ceil(ADDR_W/8) addr bytes, ceil(DATA_W/8) data
// bytes, all MSB first.
module mem_report_scheduler
    import mem_report_scheduler_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W+DATA_W-1:0] mem_num,
    input  logic                     mem_replaced,
    input  logic                     mem_valid,
    input  logic                     mem_overrun,
    output logic                     mem_ack,
`ifdef MEM_REPORT_REPLACED_FILTER_EN
    input  logic                     filter_replaced,
`endif
    input  logic [7:0]               resp_byte,
    input  logic                     resp_valid,
    output logic                     resp_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy
);

    localparam int AB = `MRS_NBYTES(ADDR_W);
    localparam int DB = `MRS_NBYTES(DATA_W);

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic              hold_full_q, hold_full_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_repl_q, hold_repl_d;
    logic              ovr_prev_q, ovr_pend_q, ovr_pend_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [AB*8-1:0]   addr_pad;
    logic [DB*8-1:0]   data_pad;
    logic              tx_hs, last_hs, drop;
    logic              arb_en, gnt_mem, gnt_resp;

    assign tx_hs   = tx_valid_q && tx_ready;
    assign last_hs = (state_q == S_DATA) && tx_hs && (cnt_q == 8'(DB));

`ifdef MEM_REPORT_REPLACED_FILTER_EN
    assign drop = filter_replaced && mem_replaced;
`else
    assign drop = 1'b0;
`endif

    // Hold arbitration for the capture cycle so a message being acked competes
    // as a ready request on the following cycle.
    assign arb_en = (state_q == S_ARB) && !ack_q;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .req_mem  (hold_full_q),
        .req_resp (resp_valid),
        .gnt_mem  (gnt_mem),
        .gnt_resp (gnt_resp)
    );

    always_comb begin
        addr_pad               = '0;
        addr_pad[ADDR_W-1:0]   = hold_addr_q;
        data_pad               = '0;
        data_pad[DATA_W-1:0]   = hold_data_q;
    end

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_repl_d = hold_repl_q;
        ovr_pend_d  = ovr_pend_q;
        tx_byte_d   = tx_byte_q;
        tx_valid_d  = tx_valid_q;
        cnt_d       = cnt_q;

        // The holding register may refill in the same cycle its last byte goes.
        ack_d = mem_valid && !ack_q && (!hold_full_q || last_hs);

        case (state_q)
            S_IDLE: state_d = S_ARB;
            S_ARB: begin
                if (gnt_mem) begin
                    tx_byte_d  = hdr_byte(ovr_pend_q, hold_repl_q);
                    tx_valid_d = 1'b1;
                    state_d    = S_HDR;
                end else if (gnt_resp) begin
                    tx_byte_d  = resp_byte;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_HDR: begin
                if (tx_hs) begin
                    if (tx_byte_q[HDR_OVR_BIT]) ovr_pend_d = 1'b0;
                    tx_byte_d = addr_pad[(AB-1)*8 +: 8];
                    cnt_d     = 8'd1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (tx_hs) begin
                    if (cnt_q == 8'(AB)) begin
                        tx_byte_d = data_pad[(DB-1)*8 +: 8];
                        cnt_d     = 8'd1;
                        state_d   = S_DATA;
                    end else begin
                        tx_byte_d = addr_pad[(AB-1-int'(cnt_q))*8 +: 8];
                        cnt_d     = cnt_q + 8'd1;
                    end
                end
            end
            S_DATA: begin
                if (tx_hs) begin
                    if (cnt_q == 8'(DB)) begin
                        tx_valid_d  = 1'b0;
                        hold_full_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        tx_byte_d = data_pad[(DB-1-int'(cnt_q))*8 +: 8];
                        cnt_d     = cnt_q + 8'd1;
                    end
                end
            end
            S_RESP: begin
                if (tx_hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Latch on the edge that closes the ack cycle; mem_manager holds the
        // word until it sees the ack.
        if (ack_q) begin
            hold_addr_d = `MRS_ADDR_FIELD(mem_num, ADDR_W, DATA_W);
            hold_data_d = `MRS_DATA_FIELD(mem_num, DATA_W);
            hold_repl_d = mem_replaced;
            hold_full_d = !drop;
        end

        // A fresh overrun edge wins over a same-cycle header clear.
        if (mem_overrun && !ovr_prev_q) ovr_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_repl_q <= 1'b0;
            ovr_prev_q  <= 1'b0;
            ovr_pend_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            hold_full_q <= hold_full_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_repl_q <= hold_repl_d;
            ovr_prev_q  <= mem_overrun;
            ovr_pend_q  <= ovr_pend_d;
            tx_byte_q   <= tx_byte_d;
            tx_valid_q  <= tx_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_ack    = ack_q;
    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = hold_full_q;
    // The response byte is consumed exactly when its TX transfer happens.
    assign resp_ready = (state_q == S_RESP) && tx_hs;

endmodule

// File: tb/tb_mem_report_scheduler.sv
module tb_mem_report_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] mem_num = '0;
    logic        mem_replaced = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_overrun = 1'b0;
    logic        mem_ack;
`ifdef MEM_REPORT_REPLACED_FILTER_EN
    logic        filter_replaced = 1'b0;
`endif
    logic [7:0]  resp_byte = 8'h00;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_report_scheduler #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_num      (mem_num),
        .mem_replaced (mem_replaced),
        .mem_valid    (mem_valid),
        .mem_overrun  (mem_overrun),
        .mem_ack      (mem_ack),
`ifdef MEM_REPORT_REPLACED_FILTER_EN
        .filter_replaced (filter_replaced),
`endif
        .resp_byte    (resp_byte),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled on the falling edge.
    logic [7:0] rx_q[$];
    int   ack_cnt = 0, rr_cnt = 0, stall_viol = 0, stall_seen = 0, ack_viol = 0;
    int   last_ack_cyc = 0, last_rise_cyc = 0;
    logic prev_stall = 1'b0, prev_ack = 1'b0, prev_vld = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_byte);
            if (mem_ack) begin
                ack_cnt      <= ack_cnt + 1;
                last_ack_cyc <= cyc;
                if (busy || prev_ack) ack_viol <= ack_viol + 1;
            end
            if (resp_ready) rr_cnt <= rr_cnt + 1;
            if (prev_stall && (!tx_valid || tx_byte != prev_byte)) stall_viol <= stall_viol + 1;
            if (tx_valid && !prev_vld) last_rise_cyc <= cyc;
            if (tx_valid && !tx_ready) stall_seen <= stall_seen + 1;
        end
        prev_stall <= !reset && tx_valid && !tx_ready;
        prev_byte  <= tx_byte;
        prev_ack   <= mem_ack;
        prev_vld   <= tx_valid;
    end

    // All stimulus tasks start and end at #1 after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_mem(input logic [7:0] a, input logic [15:0] d, input logic r,
                            output int lat);
        int t0;
        bit got;
        got = 1'b0;
        mem_num = {a, d}; mem_replaced = r; mem_valid = 1'b1; t0 = cyc;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (mem_ack) got = 1'b1;
        end
        mem_valid = 1'b0;
        lat = got ? cyc - t0 : -1;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        mem_valid = 1'b0; resp_valid = 1'b0; mem_overrun = 1'b0; tx_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (tx_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
        n_cmp++; if (tx_byte !== 8'h00)   begin n_bad++; $display("FAIL rst_tx_byte got %h exp 00", tx_byte); end
        n_cmp++; if (mem_ack !== 1'b0)    begin n_bad++; $display("FAIL rst_mem_ack got %b exp 0", mem_ack); end
        n_cmp++; if (resp_ready !== 1'b0) begin n_bad++; $display("FAIL rst_resp_ready got %b exp 0", resp_ready); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] exp [0:3];
        logic [7:0] got;
        int base, abase, lat;
        exp = '{8'h01, 8'h05, 8'hBE, 8'hEF};
        base = rx_q.size(); abase = ack_cnt;
        repeat (2) @(posedge clk); #1;
        send_mem(8'h05, 16'hBEEF, 1'b0, lat);
        wait_bytes(base + 4, 50);
        repeat (10) @(posedge clk); #1;
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_ack_latency got %0d exp 1", lat); end
        n_cmp++; if (last_rise_cyc - last_ack_cyc !== 2) begin
            n_bad++; $display("FAIL single_tx_latency got %0d exp 2", last_rise_cyc - last_ack_cyc); end
        for (int i = 0; i < 4; i++) begin
            got = (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx;
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL single_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        n_cmp++; if (rx_q.size() - base !== 4) begin n_bad++; $display("FAIL single_count got %0d exp 4", rx_q.size() - base); end
        n_cmp++; if (ack_cnt - abase !== 1) begin n_bad++; $display("FAIL single_acks got %0d exp 1", ack_cnt - abase); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [0:7];
        logic [7:0] got;
        int base, lat;
        exp = '{8'h82, 8'h05, 8'hBE, 8'hEF, 8'h01, 8'h12, 8'h34, 8'h56};
        base = rx_q.size();
        mem_overrun = 1'b1;
        repeat (2) @(posedge clk); #1;
        send_mem(8'h05, 16'hBEEF, 1'b1, lat);
        wait_bytes(base + 4, 50);
        send_mem(8'h12, 16'h3456, 1'b0, lat);
        wait_bytes(base + 8, 50);
        for (int i = 0; i < 8; i++) begin
            got = (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx;
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL overrun_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        mem_overrun = 1'b0;
    endtask

    task automatic test_arb();
        logic [7:0] exp [0:9];
        logic [7:0] got;
        int base, abase, rbase;
        exp = '{8'h01, 8'h05, 8'hBE, 8'hEF, 8'h55, 8'h01, 8'h05, 8'hBE, 8'hEF, 8'h55};
        base = rx_q.size(); abase = ack_cnt; rbase = rr_cnt;
        reset = 1'b1;
        mem_num = {8'h05, 16'hBEEF}; mem_replaced = 1'b0; mem_valid = 1'b1;
        resp_byte = 8'h55; resp_valid = 1'b1; tx_ready = 1'b1;
        do_reset();
        wait_bytes(base + 10, 100);
        mem_valid = 1'b0; resp_valid = 1'b0;
        repeat (30) @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            got = (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx;
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL arb_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        n_cmp++; if (rx_q.size() - base !== 14) begin n_bad++; $display("FAIL arb_total got %0d exp 14", rx_q.size() - base); end
        n_cmp++; if (ack_cnt - abase !== 3) begin n_bad++; $display("FAIL arb_acks got %0d exp 3", ack_cnt - abase); end
        n_cmp++; if (rr_cnt - rbase !== 2) begin n_bad++; $display("FAIL arb_resp_ready got %0d exp 2", rr_cnt - rbase); end
    endtask

    task automatic test_stall();
        logic [7:0] exp [0:3];
        logic [7:0] got;
        int base, vbase, sbase;
        exp = '{8'h01, 8'hA7, 8'h01, 8'h02};
        base = rx_q.size(); vbase = stall_viol; sbase = stall_seen;
        mem_num = {8'hA7, 16'h0102}; mem_replaced = 1'b0; mem_valid = 1'b1;
        for (int i = 0; i < 300 && rx_q.size() < base + 4; i++) begin
            tx_ready = (i % 3 == 0);
            @(posedge clk); #1;
            if (mem_ack) mem_valid = 1'b0;
        end
        mem_valid = 1'b0; tx_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            got = (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx;
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL stall_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        n_cmp++; if (stall_viol - vbase !== 0) begin n_bad++; $display("FAIL stall_stable got %0d exp 0", stall_viol - vbase); end
        n_cmp++; if (stall_seen - sbase < 2) begin n_bad++; $display("FAIL stall_cycles got %0d exp >=2", stall_seen - sbase); end
    endtask

    task automatic test_continuous();
        int base, abase, vbase, nacks, nbytes;
        base = rx_q.size(); abase = ack_cnt; vbase = ack_viol;
        mem_num = {8'h05, 16'hBEEF}; mem_replaced = 1'b0; mem_valid = 1'b1; tx_ready = 1'b1;
        repeat (60) @(posedge clk); #1;
        mem_valid = 1'b0;
        repeat (30) @(posedge clk); #1;
        nacks = ack_cnt - abase; nbytes = rx_q.size() - base;
        n_cmp++; if (nbytes !== 4 * nacks) begin n_bad++; $display("FAIL cont_bytes got %0d exp %0d", nbytes, 4 * nacks); end
        n_cmp++; if (nacks < 3) begin n_bad++; $display("FAIL cont_acks got %0d exp >=3", nacks); end
        n_cmp++; if (ack_viol - vbase !== 0) begin n_bad++; $display("FAIL cont_ack_while_full got %0d exp 0", ack_viol - vbase); end
    endtask

    task automatic test_reset_mid();
        int base, lat;
        base = rx_q.size();
        send_mem(8'h05, 16'hBEEF, 1'b0, lat);
        wait_bytes(base + 2, 50);
        tx_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_tx_valid got %b exp 0", tx_valid); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        reset = 1'b0; tx_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        n_cmp++; if (rx_q.size() - base !== 2) begin n_bad++; $display("FAIL rstmid_bytes got %0d exp 2", rx_q.size() - base); end
    endtask

`ifdef MEM_REPORT_REPLACED_FILTER_EN
    task automatic test_filter();
        logic [7:0] exp [0:3];
        logic [7:0] got;
        int base, abase, lat;
        exp = '{8'h81, 8'h33, 8'h44, 8'h55};
        base = rx_q.size(); abase = ack_cnt;
        filter_replaced = 1'b1; mem_overrun = 1'b1;
        send_mem(8'h77, 16'h8888, 1'b1, lat);
        repeat (20) @(posedge clk); #1;
        n_cmp++; if (ack_cnt - abase !== 1) begin n_bad++; $display("FAIL filt_ack got %0d exp 1", ack_cnt - abase); end
        n_cmp++; if (rx_q.size() - base !== 0) begin n_bad++; $display("FAIL filt_no_tx got %0d exp 0", rx_q.size() - base); end
        send_mem(8'h33, 16'h4455, 1'b0, lat);
        wait_bytes(base + 4, 50);
        for (int i = 0; i < 4; i++) begin
            got = (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx;
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL filt_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        filter_replaced = 1'b0; mem_overrun = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_arb();
        test_stall();
        test_continuous();
        test_reset_mid();
`ifdef MEM_REPORT_REPLACED_FILTER_EN
        test_filter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
